// File: rtl/serial_echo_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// serial_echo_scheduler_pkg
// Shared definitions for the serial echo scheduler and its push sequencer:
// pop state encodings, ACK timeout counter width and the level-width helper.
// -----------------------------------------------------------------------------
package serial_echo_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_ACK   = 3'd4,
    S_BUSY  = 3'd5
  } echo_state_t;

  // ACK_TIMEOUT is limited to 1..255, so eight bits always hold the count.
  localparam int ACK_CNT_W = 8;

  // Bits needed to hold an occupancy count of 0..size inclusive.
  function automatic int level_width(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/echo_push_sequencer.sv
// -----------------------------------------------------------------------------
// echo_push_sequencer
// Holds one received byte until it can be pushed into the shared FIFO, spaces
// push pulses so two are never adjacent, and keeps the sticky overrun flag.
//
// Ports:
//   clk          system clock
//   i_clear      synchronous active-high reset
//   i_flush      drop pending byte and clear overrun
//   i_rx_valid   one-cycle byte strobe from the receiver
//   i_rx_data    received byte
//   i_full       FIFO occupancy (already including issued pushes) is at capacity
//   i_pop_next   a pop pulse is being launched for the next cycle
//   o_push_go    a push pulse is being launched for the next cycle
//   o_waiting    a byte is pending or arriving and still has to be pushed
//   o_push       registered push pulse (FIFO push_clock)
//   o_in_data    registered FIFO write data
//   o_overrun    sticky: a byte was dropped
// -----------------------------------------------------------------------------
module echo_push_sequencer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  i_clear,
  input  logic                  i_flush,
  input  logic                  i_rx_valid,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_full,
  input  logic                  i_pop_next,
  output logic                  o_push_go,
  output logic                  o_waiting,
  output logic                  o_push,
  output logic [DATA_WIDTH-1:0] o_in_data,
  output logic                  o_overrun
);

  logic                  r_pend_valid;
  logic [DATA_WIDTH-1:0] r_pend_data;
  logic                  r_push;
  logic [DATA_WIDTH-1:0] r_in_data;
  logic                  r_overrun;

  logic                  w_rx_accept;
  logic                  w_rx_drop;
  logic [DATA_WIDTH-1:0] w_cand_data;

  // A byte is taken only when the one-entry holding slot is free and the FIFO
  // has room; the level already counts every push issued, so the slot plus
  // the level can never exceed the FIFO depth. Bytes in a flush cycle vanish
  // silently.
  always_comb begin
    w_rx_accept = i_rx_valid && !i_flush && !r_pend_valid && !i_full;
    w_rx_drop   = i_rx_valid && !i_flush && !w_rx_accept;
    o_waiting   = r_pend_valid || w_rx_accept;
    w_cand_data = r_pend_valid ? r_pend_data : i_rx_data;
    // r_push blocks a second pulse in the following cycle.
    o_push_go   = o_waiting && !r_push && !i_pop_next && !i_flush;
  end

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_push       <= 1'b0;
      r_in_data    <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_push       <= o_push_go;
      if (o_push_go) r_in_data <= w_cand_data;
      // A byte that could not go out this edge waits in the slot.
      r_pend_valid <= !i_flush && o_waiting && !o_push_go;
      if (w_rx_accept && !o_push_go) r_pend_data <= i_rx_data;
      if (i_flush)        r_overrun <= 1'b0;
      else if (w_rx_drop) r_overrun <= 1'b1;
    end
  end

  assign o_push    = r_push;
  assign o_in_data = r_in_data;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_echo_scheduler.sv
// -----------------------------------------------------------------------------
// serial_echo_scheduler
// Sequences the shared byte FIFO between UART receiver and transmitter: turns
// receive strobes into push pulses, transmitter readiness into pop pulses,
// tracks occupancy, reports overrun and owns the FIFO clear line.
//
// Handshakes: rx_valid is a one-cycle strobe with no back-pressure (a byte that
// cannot be held is dropped and flagged). Toward the transmitter, tx_start is a
// one-cycle strobe with tx_data stable from then until the FSM is back in IDLE;
// the transmitter acknowledges by raising tx_busy and finishes by dropping it.
//
// Ports:
//   clk, clear          clock, synchronous active-high reset
//   enable              allow pops (pushes always run)
//   flush               one-cycle request to empty the FIFO
//   rx_data, rx_valid   received byte and strobe
//   tx_busy             transmitter busy
//   tx_data, tx_start   byte to send and start strobe
//   fifo_in_data        FIFO write data
//   fifo_out_data       FIFO read buffer
//   fifo_push/pop/clear FIFO control pulses
//   level, empty, full  stored byte count and flags
//   overrun             sticky dropped-byte flag
//   dbg_state           current pop state
// -----------------------------------------------------------------------------
module serial_echo_scheduler
  import serial_echo_scheduler_pkg::*;
#(
  parameter int FIFO_SIZE   = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           clear,
  input  logic                           enable,
  input  logic                           flush,
  input  logic [DATA_WIDTH-1:0]          rx_data,
  input  logic                           rx_valid,
  input  logic                           tx_busy,
  output logic [DATA_WIDTH-1:0]          tx_data,
  output logic                           tx_start,
  output logic [DATA_WIDTH-1:0]          fifo_in_data,
  input  logic [DATA_WIDTH-1:0]          fifo_out_data,
  output logic                           fifo_push,
  output logic                           fifo_pop,
  output logic                           fifo_clear,
  output logic [$clog2(FIFO_SIZE+1)-1:0] level,
  output logic                           empty,
  output logic                           full,
  output logic                           overrun,
  output echo_state_t                    dbg_state
);

  localparam int                   LW        = level_width(FIFO_SIZE);
  localparam logic [LW-1:0]        LEVEL_MAX = LW'(FIFO_SIZE);
  localparam logic [ACK_CNT_W-1:0] ACK_LAST  = ACK_CNT_W'(ACK_TIMEOUT - 1);

  echo_state_t           r_state;
  echo_state_t           w_state_nxt;
  logic [ACK_CNT_W-1:0]  r_ack_cnt;
  logic [LW-1:0]         r_level;
  logic [LW-1:0]         w_level_nxt;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_pop;
  logic                  r_tx_start;
  logic                  r_fifo_clear;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  w_push_go;
  logic                  w_push_waiting;
  logic                  w_launch;

  echo_push_sequencer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_push (
    .clk        (clk),
    .i_clear    (clear),
    .i_flush    (flush),
    .i_rx_valid (rx_valid),
    .i_rx_data  (rx_data),
    .i_full     (r_full),
    .i_pop_next (w_launch),
    .o_push_go  (w_push_go),
    .o_waiting  (w_push_waiting),
    .o_push     (fifo_push),
    .o_in_data  (fifo_in_data),
    .o_overrun  (overrun)
  );

  // Pop FSM next state. Pushes win: a pop is launched only from IDLE when no
  // byte is waiting, so the two pulses can never coincide.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && (r_level != '0) && !w_push_waiting && !tx_busy && !flush) begin
          w_launch    = 1'b1;
          w_state_nxt = S_POP;
        end
      end
      S_POP:   w_state_nxt = flush ? S_IDLE : S_LOAD;
      S_LOAD:  w_state_nxt = flush ? S_IDLE : S_START;
      S_START: w_state_nxt = S_ACK;
      S_ACK: begin
        if (tx_busy)                     w_state_nxt = S_BUSY;
        else if (r_ack_cnt == ACK_LAST)  w_state_nxt = S_IDLE;
      end
      S_BUSY: begin
        if (!tx_busy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Level moves on the same edge that raises the matching pulse.
  always_comb begin
    w_level_nxt = r_level;
    if (flush)          w_level_nxt = '0;
    else if (w_push_go) w_level_nxt = r_level + 1'b1;
    else if (w_launch)  w_level_nxt = r_level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state      <= S_IDLE;
      r_ack_cnt    <= '0;
      r_level      <= '0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_pop        <= 1'b0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= '0;
      r_fifo_clear <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_ack_cnt    <= (r_state == S_ACK) ? r_ack_cnt + 1'b1 : '0;
      r_level      <= w_level_nxt;
      r_empty      <= (w_level_nxt == '0);
      r_full       <= (w_level_nxt == LEVEL_MAX);
      r_pop        <= (w_state_nxt == S_POP);
      r_tx_start   <= (w_state_nxt == S_START);
      // The read buffer shows the popped byte during the POP cycle.
      if (r_state == S_POP && !flush) r_tx_data <= fifo_out_data;
      r_fifo_clear <= flush;
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_start   = r_tx_start;
  assign fifo_pop   = r_pop;
  assign fifo_clear = r_fifo_clear;
  assign level      = r_level;
  assign empty      = r_empty;
  assign full       = r_full;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_serial_echo_scheduler.sv
// -----------------------------------------------------------------------------
// tb_serial_echo_scheduler
// Directed bench for serial_echo_scheduler with a behavioural FIFO and a
// simple transmitter model that stays busy for three cycles after tx_start.
// -----------------------------------------------------------------------------
module tb_serial_echo_scheduler;

  // ---------------- clock / reset / signals ----------------
  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       enable = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [7:0] fifo_in_data;
  logic [7:0] fifo_out_data = 8'h00;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_clear;
  logic [3:0] level;
  logic       empty;
  logic       full;
  logic       overrun;
  logic [2:0] dbg_state;

  int errors = 0;
  int checks = 0;

  logic [7:0] fq[$];
  logic [7:0] tx_log[$];
  logic [7:0] exp_q[$];
  int         n_both = 0;
  int         n_consec = 0;
  logic       prev_push = 1'b0;
  logic       tx_auto = 1'b0;
  int         bcnt = 0;

  always #5 clk = ~clk;

  serial_echo_scheduler #(
    .FIFO_SIZE   (8),
    .DATA_WIDTH  (8),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk           (clk),
    .clear         (clear),
    .enable        (enable),
    .flush         (flush),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .tx_busy       (tx_busy),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .fifo_in_data  (fifo_in_data),
    .fifo_out_data (fifo_out_data),
    .fifo_push     (fifo_push),
    .fifo_pop      (fifo_pop),
    .fifo_clear    (fifo_clear),
    .level         (level),
    .empty         (empty),
    .full          (full),
    .overrun       (overrun),
    .dbg_state     (dbg_state)
  );

  // FIFO model, pulse monitor and transmitter model, all mid-cycle.
  always @(negedge clk) begin
    if (fifo_clear === 1'b1) fq.delete();
    else begin
      if (fifo_pop === 1'b1 && fq.size() > 0) fifo_out_data = fq.pop_front();
      if (fifo_push === 1'b1 && fq.size() < 8) fq.push_back(fifo_in_data);
    end
    if (fifo_push === 1'b1 && fifo_pop === 1'b1) n_both++;
    if (fifo_push === 1'b1 && prev_push === 1'b1) n_consec++;
    prev_push = fifo_push;
    if (tx_start === 1'b1) tx_log.push_back(tx_data);
    if (tx_auto && tx_start === 1'b1) bcnt = 3;
    else if (bcnt > 0) bcnt--;
    tx_busy = tx_auto && (bcnt != 0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_start(input int max_cyc, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < max_cyc && !ok) begin
      if (tx_start === 1'b1) ok = 1'b1;
      else begin
        step();
        n++;
      end
    end
  endtask

  task automatic wait_log(input int cnt, input int max_cyc, output bit ok);
    int n;
    n = 0;
    while (n < max_cyc && tx_log.size() < cnt) begin
      step();
      n++;
    end
    ok = (tx_log.size() >= cnt);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear = 1'b1;
    step(); step();
    checks++; if (fifo_clear !== 1'b1) begin errors++; $display("FAIL reset_fifo_clear: got %b want 1", fifo_clear); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (fifo_push !== 1'b0 || fifo_pop !== 1'b0 || tx_start !== 1'b0) begin errors++; $display("FAIL reset_pulses: push=%b pop=%b start=%b want 0", fifo_push, fifo_pop, tx_start); end
    checks++; if (overrun !== 1'b0 || tx_data !== 8'h00 || fifo_in_data !== 8'h00) begin errors++; $display("FAIL reset_data: ovr=%b tx=%h in=%h want 0", overrun, tx_data, fifo_in_data); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    step();
    clear = 1'b0;
    checks++; if (fifo_clear !== 1'b1) begin errors++; $display("FAIL reset_clear_tail: got %b want 1", fifo_clear); end
    step();
    checks++; if (fifo_clear !== 1'b0) begin errors++; $display("FAIL reset_clear_drop: got %b want 0", fifo_clear); end
  endtask

  task automatic test_single_echo();
    enable  = 1'b1;
    tx_auto = 1'b1;
    step();
    send_byte(8'h41);
    checks++; if (fifo_push !== 1'b1 || fifo_in_data !== 8'h41) begin errors++; $display("FAIL echo_push: push=%b data=%h want 1/41", fifo_push, fifo_in_data); end
    checks++; if (level !== 4'd1 || fifo_pop !== 1'b0) begin errors++; $display("FAIL echo_level1: level=%0d pop=%b want 1/0", level, fifo_pop); end
    step();
    checks++; if (fifo_pop !== 1'b1 || fifo_push !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL echo_pop: pop=%b push=%b level=%0d want 1/0/0", fifo_pop, fifo_push, level); end
    step();
    checks++; if (tx_data !== 8'h41 || tx_start !== 1'b0) begin errors++; $display("FAIL echo_load: tx=%h start=%b want 41/0", tx_data, tx_start); end
    step();
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL echo_start: start=%b tx=%h want 1/41", tx_start, tx_data); end
    step();
    checks++; if (dbg_state !== 3'd4 || tx_start !== 1'b0) begin errors++; $display("FAIL echo_ack: state=%0d start=%b want 4/0", dbg_state, tx_start); end
    step();
    checks++; if (dbg_state !== 3'd5) begin errors++; $display("FAIL echo_busy: state=%0d want 5", dbg_state); end
    step(); step();
    checks++; if (dbg_state !== 3'd0 || level !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL echo_idle: state=%0d level=%0d empty=%b want 0/0/1", dbg_state, level, empty); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    enable = 1'b0;
    step();
    rx_valid = 1'b1; rx_data = 8'hA1;
    step();
    rx_data = 8'hA2;
    checks++; if (fifo_push !== 1'b1 || fifo_in_data !== 8'hA1) begin errors++; $display("FAIL b2b_push1: push=%b data=%h want 1/a1", fifo_push, fifo_in_data); end
    step();
    rx_valid = 1'b0;
    checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL b2b_gap: push=%b want 0", fifo_push); end
    step();
    checks++; if (fifo_push !== 1'b1 || fifo_in_data !== 8'hA2 || level !== 4'd2) begin errors++; $display("FAIL b2b_push2: push=%b data=%h level=%0d want 1/a2/2", fifo_push, fifo_in_data, level); end
    tx_log.delete();
    exp_q = '{8'hA1, 8'hA2};
    enable = 1'b1;
    wait_log(2, 80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_drain: got %0d strobes want 2", tx_log.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (tx_log.size() <= i || tx_log[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, (tx_log.size() > i) ? tx_log[i] : 8'hxx, exp_q[i]); end
    end
    repeat (8) step();
  endtask

  task automatic test_fill_overrun();
    bit ok;
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(i));
      step(); step();
    end
    checks++; if (level !== 4'd8 || full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL fill_full: level=%0d full=%b empty=%b want 8/1/0", level, full, empty); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fill_no_ovr: got %b want 0", overrun); end
    send_byte(8'h08);
    checks++; if (overrun !== 1'b1 || fifo_push !== 1'b0 || level !== 4'd8) begin errors++; $display("FAIL fill_overrun: ovr=%b push=%b level=%0d want 1/0/8", overrun, fifo_push, level); end
    tx_log.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
    enable = 1'b1;
    wait_log(8, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fill_drain: got %0d strobes want 8", tx_log.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (tx_log.size() <= i || tx_log[i] !== exp_q[i]) begin errors++; $display("FAIL fill_byte%0d: got %h want %h", i, (tx_log.size() > i) ? tx_log[i] : 8'hxx, exp_q[i]); end
    end
    repeat (8) step();
    checks++; if (level !== 4'd0 || empty !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL fill_after: level=%0d empty=%b ovr=%b want 0/1/1", level, empty, overrun); end
  endtask

  task automatic test_contention();
    bit ok;
    enable = 1'b0;
    tx_log.delete();
    send_byte(8'h55);
    step(); step();
    enable = 1'b1; rx_valid = 1'b1; rx_data = 8'h66;
    step();
    rx_valid = 1'b0;
    checks++; if (fifo_push !== 1'b1 || fifo_pop !== 1'b0 || fifo_in_data !== 8'h66 || level !== 4'd2) begin errors++; $display("FAIL cont_push_first: push=%b pop=%b data=%h level=%0d want 1/0/66/2", fifo_push, fifo_pop, fifo_in_data, level); end
    step();
    checks++; if (fifo_pop !== 1'b1 || fifo_push !== 1'b0 || level !== 4'd1) begin errors++; $display("FAIL cont_pop_next: pop=%b push=%b level=%0d want 1/0/1", fifo_pop, fifo_push, level); end
    exp_q = '{8'h55, 8'h66};
    wait_log(2, 80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cont_drain: got %0d strobes want 2", tx_log.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (tx_log.size() <= i || tx_log[i] !== exp_q[i]) begin errors++; $display("FAIL cont_byte%0d: got %h want %h", i, (tx_log.size() > i) ? tx_log[i] : 8'hxx, exp_q[i]); end
    end
    repeat (8) step();
  endtask

  task automatic test_ack_timeout();
    bit ok;
    tx_auto = 1'b0;
    enable  = 1'b1;
    step();
    send_byte(8'h77);
    wait_start(10, ok);
    checks++; if (!ok || tx_data !== 8'h77) begin errors++; $display("FAIL ack_first_start: ok=%b tx=%h want 1/77", ok, tx_data); end
    repeat (16) step();
    checks++; if (dbg_state !== 3'd4) begin errors++; $display("FAIL ack_wait16: state=%0d want 4", dbg_state); end
    step();
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL ack_timeout_idle: state=%0d want 0", dbg_state); end
    tx_auto = 1'b1;
    send_byte(8'h78);
    wait_start(10, ok);
    checks++; if (!ok || tx_data !== 8'h78) begin errors++; $display("FAIL ack_next_byte: ok=%b tx=%h want 1/78", ok, tx_data); end
    repeat (8) step();
  endtask

  task automatic test_flush_mid_pop();
    enable = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL flush_pre_ovr: got %b want 1", overrun); end
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hC0 + 8'(i));
      step(); step();
    end
    tx_log.delete();
    enable = 1'b1;
    step();
    checks++; if (fifo_pop !== 1'b1 || level !== 4'd3 || dbg_state !== 3'd1) begin errors++; $display("FAIL flush_in_pop: pop=%b level=%0d state=%0d want 1/3/1", fifo_pop, level, dbg_state); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (fifo_clear !== 1'b1) begin errors++; $display("FAIL flush_clear_pulse: got %b want 1", fifo_clear); end
    checks++; if (level !== 4'd0 || empty !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL flush_cleared: level=%0d empty=%b ovr=%b want 0/1/0", level, empty, overrun); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL flush_state: got %0d want 0", dbg_state); end
    repeat (10) step();
    checks++; if (tx_log.size() != 0) begin errors++; $display("FAIL flush_no_start: got %0d strobes want 0", tx_log.size()); end
    checks++; if (fifo_clear !== 1'b0 || dbg_state !== 3'd0 || level !== 4'd0) begin errors++; $display("FAIL flush_settled: clr=%b state=%0d level=%0d want 0/0/0", fifo_clear, dbg_state, level); end
    enable = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_echo();
    test_back_to_back();
    test_fill_overrun();
    test_contention();
    test_ack_timeout();
    test_flush_mid_pop();
    checks++; if (n_both != 0) begin errors++; $display("FAIL push_pop_overlap: got %0d cycles want 0", n_both); end
    checks++; if (n_consec != 0) begin errors++; $display("FAIL push_adjacent: got %0d cycles want 0", n_consec); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
